// File: rtl/adc_spi_sampler.sv
// Continuous sampler for an ADC128S022-style 12-bit SPI ADC, with optional
// power-of-two averaging of consecutive conversions.
module adc_spi_sampler #(
  parameter int unsigned CLK_HZ   = 25_000_000,
  parameter int unsigned SCLK_DIV = 13,
  parameter int unsigned CHANNEL  = 0,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned CS_GAP   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic [11:0] d_signal,
  output logic        d_valid
);

  localparam int unsigned CNT_MAX = (SCLK_DIV > CS_GAP) ? SCLK_DIV : CS_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned ACC_W   = 12 + AVG_LOG2;
  localparam int unsigned SCNT_W  = AVG_LOG2 + 1;

  localparam logic [CNT_W-1:0]  DIV_TC    = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0]  GAP_TC    = CNT_W'(CS_GAP - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [15:0]       CTRL      = {2'b00, 3'(CHANNEL), 11'd0};

  // Elaboration-time parameter sanity (ADC128S022 SCLK max is 3.2 MHz).
  if (SCLK_DIV < 2 || CS_GAP < 1 || AVG_LOG2 > 4 || CHANNEL > 7 ||
      (CLK_HZ / (2 * SCLK_DIV)) > 3_200_000) begin : g_bad_params
    $error("adc_spi_sampler: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               half_q;
  logic [3:0]         bit_q;
  logic [11:0]        shreg_q;
  logic               done_q;
  logic [ACC_W-1:0]   acc_q;
  logic [SCNT_W-1:0]  scnt_q;
  logic               cs_n_q;
  logic               sclk_q;
  logic               din_q;
  logic [11:0]        dsig_q;
  logic               dval_q;
  logic [ACC_W-1:0]   acc_sum_d;

  // Only the low 12 bits of the 16-bit frame are kept; the leading zeros shift out.
  assign acc_sum_d = acc_q + ACC_W'(shreg_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      shreg_q <= '0;
      done_q  <= 1'b0;
      acc_q   <= '0;
      scnt_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      din_q   <= 1'b0;
      dsig_q  <= '0;
      dval_q  <= 1'b0;
    end else begin
      dval_q <= 1'b0;
      done_q <= 1'b0;

      // Accumulate the sample completed on the previous cycle.
      if (done_q) begin
        if (scnt_q == SCNT_LAST) begin
          dsig_q <= 12'(acc_sum_d >> AVG_LOG2);
          dval_q <= 1'b1;
          acc_q  <= '0;
          scnt_q <= '0;
        end else begin
          acc_q  <= acc_sum_d;
          scnt_q <= scnt_q + SCNT_W'(1);
        end
      end

      case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= SETUP;
            cs_n_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        SETUP: begin
          if (cnt_q == DIV_TC) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            half_q  <= 1'b0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            din_q   <= CTRL[15];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (cnt_q == DIV_TC) begin
            cnt_q <= '0;
            if (!half_q) begin
              half_q  <= 1'b1;
              sclk_q  <= 1'b1;
              shreg_q <= {shreg_q[10:0], adc_dout};
              if (bit_q == 4'd15) begin
                done_q <= 1'b1;
              end
            end else if (bit_q == 4'd15) begin
              state_q <= HOLD;
            end else begin
              half_q <= 1'b0;
              sclk_q <= 1'b0;
              bit_q  <= bit_q + 4'd1;
              din_q  <= CTRL[4'd14 - bit_q];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt_q == DIV_TC) begin
            state_q <= GAP;
            cs_n_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == GAP_TC) begin
            cnt_q <= '0;
            if (en) begin
              state_q <= SETUP;
              cs_n_q  <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign adc_cs_n = cs_n_q;
  assign adc_sclk = sclk_q;
  assign adc_din  = din_q;
  assign d_signal = dsig_q;
  assign d_valid  = dval_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench: two samplers (raw ch5, 4x-average ch3) against ADC models and a
// queue scoreboard; frame timing, control word and reset/enable behaviour.
module tb_adc_spi_sampler;

  localparam int DIV    = 13;
  localparam int GAPLEN = 16;
  localparam int PERIOD = DIV * 34 + GAPLEN;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       cs_n, sclk, din, dout;
  logic [1:0]       dval;
  logic [1:0][11:0] dsig;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int avg_log2 [2] = '{0, 2};
  int chan     [2] = '{5, 3};

  // ADC model / reference state, one slot per DUT
  int src0[$];
  int src1[$];
  int exp0[$];
  int exp1[$];
  logic [15:0] cur_word [2];
  logic [15:0] din_word [2];
  int edges [2], falls [2], frames [2], cs_falls [2];
  int pend_sum [2], pend_n [2];
  int fall_cyc [2], rise_cyc [2], sclk_cyc [2], rise16_cyc [2];
  bit prev_cs [2], prev_sclk [2], in_frame [2], have_rise [2], cont [2];
  int last_exp [2];
  bit prev_val [2];

  adc_spi_sampler #(.SCLK_DIV(DIV), .CS_GAP(GAPLEN), .CHANNEL(5), .AVG_LOG2(0)) u_raw (
    .clk(clk), .rst(rst), .en(en),
    .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .adc_din(din[0]), .adc_dout(dout[0]),
    .d_signal(dsig[0]), .d_valid(dval[0])
  );

  adc_spi_sampler #(.SCLK_DIV(DIV), .CS_GAP(GAPLEN), .CHANNEL(3), .AVG_LOG2(2)) u_avg (
    .clk(clk), .rst(rst), .en(en),
    .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .adc_din(din[1]), .adc_dout(dout[1]),
    .d_signal(dsig[1]), .d_valid(dval[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int next_sample(input int d);
    if (d == 0 && src0.size() > 0) return src0.pop_front();
    if (d == 1 && src1.size() > 0) return src1.pop_front();
    return int'($urandom_range(4095, 0));
  endfunction

  // ADC model plus timing and control-word checks, sampled on the falling clk edge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        pend_sum[d] = 0;
        pend_n[d] = 0;
        in_frame[d] = 0;
        have_rise[d] = 0;
        cont[d] = 0;
        dout[d] = 1'b0;
      end else begin
        if (!en) cont[d] = 0;
        if (prev_cs[d] && !cs_n[d]) begin
          if (cont[d] && have_rise[d]) begin
            check($sformatf("cs_gap_%0d", d), cyc - rise_cyc[d], GAPLEN);
            check($sformatf("frame_period_%0d", d), cyc - fall_cyc[d], PERIOD);
          end
          cont[d] = 1;
          cs_falls[d]++;
          fall_cyc[d] = cyc;
          sclk_cyc[d] = cyc;
          cur_word[d] = {4'b0000, 12'(next_sample(d))};
          din_word[d] = '0;
          edges[d] = 0;
          falls[d] = 0;
          in_frame[d] = 1;
        end else if (!cs_n[d] && in_frame[d]) begin
          if (prev_sclk[d] && !sclk[d]) begin
            check($sformatf("sclk_high_%0d", d), cyc - sclk_cyc[d], DIV);
            sclk_cyc[d] = cyc;
            dout[d] = cur_word[d][15 - falls[d]];
            falls[d]++;
          end else if (!prev_sclk[d] && sclk[d]) begin
            check($sformatf("sclk_low_%0d", d), cyc - sclk_cyc[d], DIV);
            sclk_cyc[d] = cyc;
            din_word[d] = {din_word[d][14:0], din[d]};
            edges[d]++;
            if (edges[d] == 16) begin
              frames[d]++;
              rise16_cyc[d] = cyc;
              check($sformatf("din_word_%0d", d), int'(din_word[d]), chan[d] * 2048);
              pend_sum[d] += int'(cur_word[d][11:0]);
              pend_n[d]++;
              if (pend_n[d] == (1 << avg_log2[d])) begin
                if (d == 0) exp0.push_back(pend_sum[d] >> avg_log2[d]);
                else        exp1.push_back(pend_sum[d] >> avg_log2[d]);
                pend_sum[d] = 0;
                pend_n[d] = 0;
              end
            end
          end
        end else if (!prev_cs[d] && cs_n[d] && in_frame[d]) begin
          check($sformatf("edges_per_frame_%0d", d), edges[d], 16);
          in_frame[d] = 0;
          rise_cyc[d] = cyc;
          have_rise[d] = 1;
        end
      end
      prev_cs[d] = cs_n[d];
      prev_sclk[d] = sclk[d];
    end
  end

  // Scoreboard monitor: pops an expected result for every d_valid strobe
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        if (d == 0) exp0.delete(); else exp1.delete();
        last_exp[d] = 0;
        prev_val[d] = 0;
      end else begin
        if (dval[d]) begin
          if ((d == 0 && exp0.size() == 0) || (d == 1 && exp1.size() == 0)) begin
            check($sformatf("unexpected_valid_%0d", d), 1, 0);
          end else begin
            last_exp[d] = (d == 0) ? exp0.pop_front() : exp1.pop_front();
            check($sformatf("d_signal_%0d", d), int'(dsig[d]), last_exp[d]);
            check($sformatf("valid_latency_%0d", d), cyc - rise16_cyc[d], 1);
          end
        end else if (prev_val[d]) begin
          check($sformatf("d_signal_hold_%0d", d), int'(dsig[d]), last_exp[d]);
        end
        prev_val[d] = dval[d];
      end
    end
  end

  task automatic wait_frames(input int n);
    int target;
    bit done;
    target = frames[1] + n;
    done = 0;
    for (int i = 0; i < n * (PERIOD + 20) + 200 && !done; i++) begin
      @(negedge clk);
      if (frames[1] >= target) done = 1;
    end
    if (!done) check("wait_frames_timeout", 0, 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_edge(input int k);
    bit done;
    done = 0;
    for (int i = 0; i < 3 * PERIOD && !done; i++) begin
      @(posedge clk); #1;
      if (in_frame[0] && edges[0] == k) done = 1;
    end
    if (!done) check("wait_edge_timeout", 0, 1);
  endtask

  initial begin
    int bad;
    int falls_before;
    rst = 1'b1;
    en  = 1'b0;
    src0.push_back(12'hABC);
    src1.push_back(1000); src1.push_back(1002); src1.push_back(1004); src1.push_back(1006);
    for (int i = 0; i < 4; i++) src1.push_back(4095);
    src1.push_back(0); src1.push_back(0); src1.push_back(0); src1.push_back(3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cs_n", int'(cs_n), 3);
    check("reset_sclk", int'(sclk), 3);
    check("reset_din", int'(din), 0);
    check("reset_d_signal", int'(dsig[0]) + int'(dsig[1]), 0);
    check("reset_d_valid", int'(dval), 0);

    @(posedge clk); #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sclk != 2'b11 || cs_n != 2'b11 || dval != 2'b00) bad++;
    end
    check("idle_no_activity", bad, 0);

    // Continuous run: raw 0xABC, then averages of the fixed sample sets
    @(posedge clk); #1 en = 1'b1;
    wait_frames(14);

    // en dropped mid-frame: frame completes, then the sampler stays idle
    wait_edge(7);
    en = 1'b0;
    repeat (2 * PERIOD) @(negedge clk);
    falls_before = cs_falls[0];
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (cs_n != 2'b11 || sclk != 2'b11) bad++;
    end
    check("idle_after_en_drop", bad, 0);
    check("no_frame_after_en_drop", cs_falls[0], falls_before);

    @(posedge clk); #1 en = 1'b1;
    wait_frames(3);

    // Reset mid-frame aborts the conversion immediately
    wait_edge(9);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_cs_n", int'(cs_n), 3);
    check("abort_sclk", int'(sclk), 3);
    check("abort_d_valid", int'(dval), 0);
    @(posedge clk); #1 rst = 1'b0;
    wait_frames(6);

    @(posedge clk); #1 en = 1'b0;
    repeat (2 * PERIOD) @(negedge clk);
    check("raw_queue_drained", exp0.size(), 0);
    check("avg_queue_drained", exp1.size(), 0);
    check("final_cs_n_idle", int'(cs_n), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
